// File: rtl/stim_seq_gen.sv
// Stimulus sequencer: replays a programmed table of (pattern, hold count) entries onto x,
// with one-shot or looping playback, abort, and done/wrap pulses.
`timescale 1ns/1ps
module stim_seq_gen #(
  parameter int              N_CH     = 2,
  parameter int              DEPTH    = 16,
  parameter int              DUR_W    = 8,
  parameter logic [N_CH-1:0] IDLE_VAL = '0,
  localparam int             AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [N_CH-1:0]  wr_val,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW-1:0]    last_addr,
  input  logic             loop_en,
  input  logic             start,
  input  logic             abort,
  output logic [N_CH-1:0]  x,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             done,
  output logic             wrap
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [N_CH-1:0]  val_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [N_CH-1:0]  x_q, x_d;
  logic [AW-1:0]    step_q, step_d;
  logic [AW-1:0]    last_q, last_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             load;
  logic [AW-1:0]    load_idx;
  logic             step_end;

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      val_mem[wr_addr] <= wr_val;
      dur_mem[wr_addr] <= wr_dur;
    end
  end

  assign step_end = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    step_d   = step_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    load     = 1'b0;
    load_idx = step_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          load     = 1'b1;
          load_idx = '0;
          last_d   = last_addr;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          x_d     = IDLE_VAL;
          step_d  = '0;
        end else if (!step_end) begin
          cnt_d = cnt_q - 1'b1;
        end else if (step_q == last_q) begin
          if (loop_en) begin
            load     = 1'b1;
            load_idx = '0;
            last_d   = last_addr;
            wrap_d   = 1'b1;
          end else begin
            state_d = IDLE;
            x_d     = IDLE_VAL;
            step_d  = '0;
            done_d  = 1'b1;
          end
        end else begin
          load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = IDLE_VAL;
        step_d  = '0;
      end
    endcase

    // Entry contents are captured only here, so writes to a running entry land on its next load.
    if (load) begin
      x_d    = val_mem[load_idx];
      cnt_d  = dur_mem[load_idx];
      step_d = load_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= IDLE_VAL;
      step_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      step_q  <= step_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign x        = x_q;
  assign busy     = (state_q == RUN);
  assign step_idx = step_q;
  assign done     = done_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stim_seq_gen.sv
// Scoreboard bench for stim_seq_gen: a step-list reference model predicts each cycle's outputs,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_stim_seq_gen;
  localparam int N_CH  = 2;
  localparam int DEPTH = 16;
  localparam int DUR_W = 8;
  localparam int AW    = 4;
  localparam logic [N_CH-1:0] IDLE_V = 2'b00;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [N_CH-1:0]  wr_val = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [AW-1:0]    last_addr = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_CH-1:0]  x;
  logic             busy;
  logic [AW-1:0]    step_idx;
  logic             done;
  logic             wrap;

  stim_seq_gen #(.N_CH(N_CH), .DEPTH(DEPTH), .DUR_W(DUR_W), .IDLE_VAL(IDLE_V)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_val(wr_val),
    .wr_dur(wr_dur), .last_addr(last_addr), .loop_en(loop_en), .start(start),
    .abort(abort), .x(x), .busy(busy), .step_idx(step_idx), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     tag;
    logic [N_CH-1:0] x;
    logic            busy;
    logic [AW-1:0]   step;
    logic            done;
    logic            wrap;
  } exp_t;

  exp_t q[$];
  int unsigned cyc = 0;
  int n_total = 0;
  int n_pass  = 0;

  // Reference model: table copy plus "which step, how many display cycles left".
  logic [N_CH-1:0] m_val [DEPTH];
  int              m_dur [DEPTH];
  bit              m_run = 0;
  int              m_step = 0;
  int              m_left = 0;
  int              m_last = 0;
  logic [N_CH-1:0] m_x = IDLE_V;
  bit              m_done = 0;
  bit              m_wrap = 0;

  function automatic void m_load(int idx);
    m_step = idx;
    m_left = m_dur[idx] + 1;
    m_x    = m_val[idx];
  endfunction

  function automatic void model_edge();
    m_done = 0;
    m_wrap = 0;
    if (!m_run) begin
      if (start && !abort) begin
        m_run  = 1;
        m_last = int'(last_addr);
        m_load(0);
      end
    end else if (abort) begin
      m_run = 0; m_x = IDLE_V; m_step = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_step == m_last) begin
          if (loop_en) begin
            m_wrap = 1;
            m_last = int'(last_addr);
            m_load(0);
          end else begin
            m_run = 0; m_done = 1; m_x = IDLE_V; m_step = 0;
          end
        end else begin
          m_load((m_step + 1) % DEPTH);
        end
      end
    end
    if (wr_en) begin
      m_val[wr_addr] = wr_val;
      m_dur[wr_addr] = int'(wr_dur);
    end
  endfunction

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].tag < cyc) begin
      e = q.pop_front();
      n_total++;
      $display("FAIL stale_entry: tag %0d unchecked at cycle %0d", e.tag, cyc);
    end
    if (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      n_total++;
      if (x === e.x && busy === e.busy && step_idx === e.step && done === e.done && wrap === e.wrap)
        n_pass++;
      else
        $display("FAIL cycle%0d: got x=%b busy=%b step=%0d done=%b wrap=%b required x=%b busy=%b step=%0d done=%b wrap=%b",
                 cyc, x, busy, step_idx, done, wrap, e.x, e.busy, e.step, e.done, e.wrap);
    end
  end

  task automatic step_cycle();
    exp_t e;
    model_edge();
    e.tag  = cyc + 1;
    e.x    = m_x;
    e.busy = m_run;
    e.step = AW'(m_step);
    e.done = m_done;
    e.wrap = m_wrap;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(int n);
    repeat (n) step_cycle();
  endtask

  task automatic wr(int a, int v, int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_val = N_CH'(v); wr_dur = DUR_W'(d);
    step_cycle();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_x", 32'(x), 32'(IDLE_V));
    check("async_rst_busy_done", {30'd0, busy, done}, 32'd0);
    m_run = 0; m_x = IDLE_V; m_step = 0; m_done = 0; m_wrap = 0;
    start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #3;
    check("reset_state", {x, busy, step_idx, done, wrap}, {IDLE_V, 1'b0, 4'd0, 1'b0, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) wr(i, i % 4, i % 3);

    // One-shot: 01 x1, 00 x2, 10 x20, 11 x2, then idle with done.
    wr(0, 1, 0); wr(1, 0, 1); wr(2, 2, 19); wr(3, 3, 1);
    last_addr = 4'd3; loop_en = 1'b0;
    pulse_start();
    run(30);

    // Loop mode, then drop loop_en to finish after the next pass.
    loop_en = 1'b1;
    pulse_start();
    run(60);
    loop_en = 1'b0;
    run(30);

    // Abort during step 2, then abort+start together in IDLE.
    pulse_start();
    run(4);
    abort = 1'b1; step_cycle(); abort = 1'b0;
    run(3);
    start = 1'b1; abort = 1'b1; run(3);
    start = 1'b0; abort = 1'b0; run(2);

    // Async reset mid-sequence, then a clean replay.
    pulse_start();
    run(5);
    async_reset();
    pulse_start();
    run(30);

    // Single-step loop with dur 0: wrap every cycle.
    wr(0, 2, 0); last_addr = 4'd0; loop_en = 1'b1;
    pulse_start();
    run(10);
    loop_en = 1'b0;
    run(3);

    // Maximum hold count: 256 cycles.
    wr(0, 1, 255);
    pulse_start();
    run(262);

    // Rewrite entry 2 while it is on x.
    wr(0, 1, 0); last_addr = 4'd3; loop_en = 1'b1;
    pulse_start();
    run(4);
    wr(2, 1, 5);
    run(50);
    loop_en = 1'b0;
    run(30);

    // start held high: restarts the cycle after done.
    last_addr = 4'd1;
    start = 1'b1; run(20);
    start = 1'b0; run(6);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_val  = N_CH'($urandom);
      wr_dur  = ($urandom_range(0, 15) == 0) ? DUR_W'($urandom) : DUR_W'($urandom_range(0, 4));
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 19) == 0) last_addr = AW'($urandom_range(0, DEPTH - 1));
      if (i == 2000) async_reset();
      else step_cycle();
    end

    wr_en = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    run(2);
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
